dispatch_reader: RTL

Read-side companion to the dispatch RAM interface. It tracks entries the producer has committed and walks the RAM in ring order through the RAM's read port. Each entry is presented to the consuming core over a valid/ready handshake. A 2-entry output buffer absorbs the RAM's 1-cycle read latency so the core sees full throughput under backpressure.

---
 rtl/dispatch_reader.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dispatch_reader.sv
// rtl/dispatch_reader.sv - ring-order reader of the dispatch RAM feeding a 2-entry task buffer
// Define DISPATCH_READER_STATS_EN to add delivered/stall counters and their ports.
module dispatch_reader #(
  parameter int CORE        = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic                   flush_i,
  output logic                   ram_read_o,
  output logic [INDEX_WIDTH-1:0] ram_address_o,
  input  logic [DATA_WIDTH-1:0]  ram_data_i,
  output logic                   task_valid_o,
  input  logic                   task_ready_i,
  output logic [DATA_WIDTH-1:0]  task_data_o,
  output logic [INDEX_WIDTH-1:0] task_index_o,
  output logic [INDEX_WIDTH:0]   level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  output logic                   busy_o,
`ifdef DISPATCH_READER_STATS_EN
  output logic [31:0]            stat_delivered_o,
  output logic [31:0]            stat_stalls_o,
`endif
  input  logic                   report_i
);

  localparam logic [INDEX_WIDTH:0]   LVL_DEPTH = {1'b1, {INDEX_WIDTH{1'b0}}};
  localparam logic [INDEX_WIDTH:0]   LVL_ONE   = {{INDEX_WIDTH{1'b0}}, 1'b1};
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE   = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                            state_q, state_d;
  logic [INDEX_WIDTH-1:0]            head_q, head_d;
  logic [INDEX_WIDTH-1:0]            tail_q, tail_d;
  logic [INDEX_WIDTH:0]              pending_q, pending_d;
  logic [INDEX_WIDTH:0]              level_q, level_d;
  logic                              overflow_q, overflow_d;
  logic                              inflight_q, inflight_d;
  logic [INDEX_WIDTH-1:0]            inflight_idx_q, inflight_idx_d;
  logic [1:0][DATA_WIDTH-1:0]        buf_data_q, buf_data_d;
  logic [1:0][INDEX_WIDTH-1:0]       buf_idx_q, buf_idx_d;
  logic [1:0]                        buf_cnt_q, buf_cnt_d;

  logic       run;
  logic       full;
  logic       task_valid;
  logic       transfer;
  logic       push_ok;
  logic       rd_issue;
  logic [1:0] occupancy;

  assign run        = (state_q == ST_RUN);
  assign full       = (level_q == LVL_DEPTH);
  assign task_valid = run && (buf_cnt_q != 2'd0);
  assign transfer   = task_valid && task_ready_i;
  assign push_ok    = run && push_i && (!full || transfer);

  // A slot leaving the buffer this cycle is credited back immediately, so a
  // read can be issued in the same cycle and the core sees one task per cycle.
  assign occupancy  = buf_cnt_q + {1'b0, inflight_q} - {1'b0, transfer};
  assign rd_issue   = run && (pending_q != '0) && (occupancy < 2'd2);

  assign ram_read_o    = rd_issue;
  assign ram_address_o = head_q;
  assign task_valid_o  = task_valid;
  assign task_data_o   = buf_data_q[0];
  assign task_index_o  = buf_idx_q[0];
  assign level_o       = level_q;
  assign full_o        = full;
  assign empty_o       = (level_q == '0);
  assign overflow_o    = overflow_q;
  assign busy_o        = (state_q == ST_FLUSH);

  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    pending_d      = pending_q;
    level_d        = level_q;
    overflow_d     = overflow_q;
    inflight_d     = inflight_q;
    inflight_idx_d = inflight_idx_q;
    buf_data_d     = buf_data_q;
    buf_idx_d      = buf_idx_q;
    buf_cnt_d      = buf_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_FLUSH;
        end
        if (push_ok) begin
          tail_d = tail_q + IDX_ONE;
        end
        if (rd_issue) begin
          head_d = head_q + IDX_ONE;
        end
        inflight_d     = rd_issue;
        inflight_idx_d = head_q;

        case ({push_ok, rd_issue})
          2'b10:   pending_d = pending_q + LVL_ONE;
          2'b01:   pending_d = pending_q - LVL_ONE;
          default: pending_d = pending_q;
        endcase

        case ({push_ok, transfer})
          2'b10:   level_d = level_q + LVL_ONE;
          2'b01:   level_d = level_q - LVL_ONE;
          default: level_d = level_q;
        endcase

        if (push_i && full && !transfer) begin
          overflow_d = 1'b1;
        end

        // Pop first, then append the landing read behind whatever remains.
        if (transfer) begin
          buf_data_d[0] = buf_data_q[1];
          buf_idx_d[0]  = buf_idx_q[1];
          buf_cnt_d     = buf_cnt_q - 2'd1;
        end
        if (inflight_q) begin
          if (buf_cnt_d == 2'd0) begin
            buf_data_d[0] = ram_data_i;
            buf_idx_d[0]  = inflight_idx_q;
          end else begin
            buf_data_d[1] = ram_data_i;
            buf_idx_d[1]  = inflight_idx_q;
          end
          buf_cnt_d = buf_cnt_d + 2'd1;
        end
      end

      ST_FLUSH: begin
        // Any read landing now is dropped; resync once the RAM port is idle.
        inflight_d = 1'b0;
        if (!inflight_q) begin
          buf_cnt_d = 2'd0;
          head_d    = tail_q;
          pending_d = '0;
          level_d   = '0;
          state_d   = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= ST_RUN;
      head_q         <= '0;
      tail_q         <= '0;
      pending_q      <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      buf_data_q     <= '0;
      buf_idx_q      <= '0;
      buf_cnt_q      <= 2'd0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      pending_q      <= pending_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      buf_data_q     <= buf_data_d;
      buf_idx_q      <= buf_idx_d;
      buf_cnt_q      <= buf_cnt_d;
    end
  end

`ifdef DISPATCH_READER_STATS_EN
  logic [31:0] delivered_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      delivered_q <= '0;
      stalls_q    <= '0;
    end else begin
      if (transfer) begin
        delivered_q <= delivered_q + 32'd1;
      end
      if (task_valid && !task_ready_i) begin
        stalls_q <= stalls_q + 32'd1;
      end
    end
  end

  assign stat_delivered_o = delivered_q;
  assign stat_stalls_o    = stalls_q;
`endif

`ifndef SYNTHESIS
  logic [31:0] cycle_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
    if (report_i) begin
`ifdef DISPATCH_READER_STATS_EN
      $display("dispatch_reader core=%0d cycle=%0d head=%0d tail=%0d level=%0d task_valid=%0b task_ready=%0b task_data=%0h state=%s delivered=%0d stalls=%0d",
               CORE, cycle_q, head_q, tail_q, level_q, task_valid, task_ready_i,
               buf_data_q[0], (state_q == ST_RUN) ? "RUN" : "FLUSH", delivered_q, stalls_q);
`else
      $display("dispatch_reader core=%0d cycle=%0d head=%0d tail=%0d level=%0d task_valid=%0b task_ready=%0b task_data=%0h state=%s",
               CORE, cycle_q, head_q, tail_q, level_q, task_valid, task_ready_i,
               buf_data_q[0], (state_q == ST_RUN) ? "RUN" : "FLUSH");
`endif
    end
  end
`endif

endmodule
